mdio_frame_master: RTL and testbench

//  Parametrised MDIO management master: serialises one 32-bit management frame from
//  t_data onto MDC/MDIO, with configurable preamble and MDC divider. Clause-22 and

---
 rtl/mdio_frame_master.sv | 147 ++++++++++++++
 tb/tb_mdio_frame_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mdio_frame_master.sv
// MDIO management master: shifts one Clause-22/45 frame out on mdc/mdio and captures read data.
// Frame occupies (PREAMBLE_LEN+32)*2*CLK_DIV cycles plus one DONE cycle; mdio_start is ignored while busy.
module mdio_frame_master #(
  parameter int CLK_DIV      = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        rd_err
);

  localparam int PW     = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int MAXLEN = (PREAMBLE_LEN > 18) ? PREAMBLE_LEN : 18;
  localparam int BW     = $clog2(MAXLEN + 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, WDAT, RTA, RDAT, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ph, ph_n;
  logic [BW-1:0] bit_cnt, bit_n, last_bit;
  logic [31:0]   tx, tx_n;
  logic [15:0]   rx, rx_n;
  logic          is_rd, is_rd_n;
  logic          ta, ta_n;
  logic          bit_end, active_n;
  logic          mdc_n, mdio_out_n, mdio_oe_n, busy_n;
  logic [15:0]   rd_data_n;
  logic          data_rdy_n, rd_err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ph       <= '0;
      bit_cnt  <= '0;
      tx       <= '0;
      rx       <= '0;
      is_rd    <= 1'b0;
      ta       <= 1'b0;
      mdc      <= 1'b0;
      mdio_out <= 1'b0;
      mdio_oe  <= 1'b0;
      busy     <= 1'b0;
      rd_data  <= '0;
      data_rdy <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      bit_cnt  <= bit_n;
      tx       <= tx_n;
      rx       <= rx_n;
      is_rd    <= is_rd_n;
      ta       <= ta_n;
      mdc      <= mdc_n;
      mdio_out <= mdio_out_n;
      mdio_oe  <= mdio_oe_n;
      busy     <= busy_n;
      rd_data  <= rd_data_n;
      data_rdy <= data_rdy_n;
      rd_err   <= rd_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    ph_n       = ph;
    bit_n      = bit_cnt;
    tx_n       = tx;
    rx_n       = rx;
    is_rd_n    = is_rd;
    ta_n       = ta;
    rd_data_n  = rd_data;
    rd_err_n   = rd_err;
    data_rdy_n = 1'b0;
    bit_end    = (ph == PH_LAST);

    case (state)
      PRE:     last_bit = BW'(PREAMBLE_LEN - 1);
      HDR:     last_bit = BW'(13);
      WDAT:    last_bit = BW'(17);
      RTA:     last_bit = BW'(1);
      RDAT:    last_bit = BW'(15);
      default: last_bit = '0;
    endcase

    case (state)
      IDLE: begin
        if (mdio_start) begin
          tx_n    = t_data;
          is_rd_n = t_data[29];
          ph_n    = '0;
          bit_n   = '0;
          state_n = (PREAMBLE_LEN > 0) ? PRE : HDR;
        end
      end
      DONE: state_n = IDLE;
      default: begin
        ph_n = bit_end ? '0 : ph + PW'(1);
        // The edge that raises mdc is the PHY-data sample point.
        if (ph == PH_RISE) begin
          if (state == RTA && bit_cnt == BW'(1)) ta_n = mdio_in;
          if (state == RDAT) rx_n = {rx[14:0], mdio_in};
        end
        if (bit_end) begin
          if (state == HDR || state == WDAT) tx_n = {tx[30:0], 1'b0};
          if (bit_cnt == last_bit) begin
            bit_n = '0;
            case (state)
              PRE:     state_n = HDR;
              HDR:     state_n = is_rd ? RTA : WDAT;
              RTA:     state_n = RDAT;
              default: state_n = DONE;
            endcase
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
    endcase

    // Pin values are registered from the next state so they change at the start of the low phase.
    active_n   = state_n inside {PRE, HDR, WDAT, RTA, RDAT};
    busy_n     = active_n;
    mdc_n      = active_n && (ph_n >= PH_HIGH);
    mdio_oe_n  = state_n inside {PRE, HDR, WDAT};
    mdio_out_n = (state_n == PRE) || ((state_n == HDR || state_n == WDAT) && tx_n[31]);

    if (state == RDAT && state_n == DONE) begin
      rd_data_n  = rx_n;
      rd_err_n   = ta;
      data_rdy_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_mdio_frame_master.sv
// Bench for mdio_frame_master: two instances (CLK_DIV=2/PRE=32 and CLK_DIV=1/PRE=0) checked against a bit-list PHY model.
module tb_mdio_frame_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mdio_in, sel;
  logic [31:0] t_data;
  logic        start0, start1;
  logic        mdc0, out0, oe0, busy0, rdy0, err0;
  logic        mdc1, out1, oe1, busy1, rdy1, err1;
  logic [15:0] rd0, rd1;
  logic        mdc_m, out_m, oe_m, busy_m, rdy_m, err_m;
  logic [15:0] rd_m;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign mdc_m  = sel ? mdc1  : mdc0;
  assign out_m  = sel ? out1  : out0;
  assign oe_m   = sel ? oe1   : oe0;
  assign busy_m = sel ? busy1 : busy0;
  assign rdy_m  = sel ? rdy1  : rdy0;
  assign err_m  = sel ? err1  : err0;
  assign rd_m   = sel ? rd1   : rd0;

  mdio_frame_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut0 (
    .clk(clk), .reset(reset), .mdio_start(start0), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc0), .mdio_out(out0), .mdio_oe(oe0), .busy(busy0),
    .rd_data(rd0), .data_rdy(rdy0), .rd_err(err0));

  mdio_frame_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) u_dut1 (
    .clk(clk), .reset(reset), .mdio_start(start1), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1), .busy(busy1),
    .rd_data(rd1), .data_rdy(rdy1), .rd_err(err1));

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_rd [2];
  logic        exp_err [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one frame on the selected instance; caller must be at a negedge with the DUT idle.
  task automatic run_frame(input logic [31:0] td, input logic [15:0] pdat, input bit absent,
                           input bit repulse, input int abort_bit);
    int pre, dv, n, busy_cnt, rises, rdy_cnt, guard, k;
    bit rd, done, prev;
    logic [1:0] expq[$];
    logic       phyq[$];
    pre = sel ? 0 : 32;
    dv  = sel ? 1 : 2;
    n   = pre + 32;
    rd  = td[29];
    for (int i = 0; i < n; i++) begin
      k = i - pre;
      if (i < pre) expq.push_back(2'b11);
      else if (!rd || k < 14) expq.push_back({1'b1, td[31-k]});
      else expq.push_back(2'b00);
      if (!rd || k < 14 || absent) phyq.push_back(1'b1);
      else if (k == 14) phyq.push_back(1'b1);
      else if (k == 15) phyq.push_back(1'b0);
      else phyq.push_back(pdat[31-k]);
    end

    mdio_in = phyq[0];
    t_data  = td;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_accept", {31'd0, busy_m}, 32'd1);
    busy_cnt = 0; rises = 0; rdy_cnt = 0; guard = 0; done = 0; prev = 1'b0;
    while (!done && guard < n * 2 * dv + 8) begin
      guard++;
      start = repulse && (busy_cnt == 20);
      if (repulse) t_data = ~td;
      if (busy_m) busy_cnt++;
      if (rdy_m) rdy_cnt++;
      if (mdc_m && !prev) begin
        if (rises < n) check($sformatf("bit%0d", rises), {30'd0, oe_m, oe_m & out_m}, {30'd0, expq[rises]});
        rises++;
        if (rises < n) mdio_in = phyq[rises];
        if (abort_bit >= 0 && rises == abort_bit) begin
          reset = 1'b0;
          #1;
          check("abort_outputs", {10'd0, mdc_m, out_m, oe_m, busy_m, rdy_m, err_m, rd_m}, 32'd0);
          for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_rdy", {31'd0, rdy_m}, 32'd0);
          end
          reset = 1'b1;
          exp_rd[sel]  = 16'h0;
          exp_err[sel] = 1'b0;
          @(negedge clk);
          check("abort_idle", {31'd0, busy_m}, 32'd0);
          return;
        end
      end
      prev = mdc_m;
      if (!busy_m) done = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      check("timeout", 32'd1, 32'd0);
      return;
    end
    check("busy_len", busy_cnt, n * 2 * dv);
    check("mdc_rises", rises, n);
    check("done_pins", {29'd0, mdc_m, oe_m, out_m}, 32'd0);
    check("done_rdy", {31'd0, rdy_m}, {31'd0, rd});
    @(negedge clk);
    check("rdy_width", {31'd0, rdy_m}, 32'd0);
    check("rdy_count", rdy_cnt, rd ? 1 : 0);
    if (rd) begin
      exp_rd[sel]  = absent ? 16'hFFFF : pdat;
      exp_err[sel] = absent;
    end
    check("rd_data", {16'd0, rd_m}, {16'd0, exp_rd[sel]});
    check("rd_err", {31'd0, err_m}, {31'd0, exp_err[sel]});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; t_data = '0; mdio_in = 1'b1; sel = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset0", {10'd0, mdc0, out0, oe0, busy0, rdy0, err0, rd0}, 32'd0);
    check("reset1", {10'd0, mdc1, out1, oe1, busy1, rdy1, err1, rd1}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_frame(32'h5AB87654, 16'h0000, 0, 0, -1);
    run_frame(32'h6AB80000, 16'hBEEF, 0, 0, -1);
    run_frame(32'h6AB80000, 16'hBEEF, 1, 0, -1);
    run_frame(32'h5AB87654, 16'h0000, 0, 1, -1);
    run_frame(32'h6AB80000, 16'h1234, 0, 1, -1);
    run_frame(32'h6AB80000, 16'hCAFE, 0, 0, 40);
    run_frame(32'h6AB80000, 16'hA5C3, 0, 0, -1);
    for (int i = 0; i < 10; i++)
      run_frame($urandom, 16'($urandom), $urandom_range(0, 7) == 0, 0, -1);

    sel = 1'b1;
    @(negedge clk);
    run_frame(32'h5AB87654, 16'h0000, 0, 0, -1);
    run_frame(32'h6AB80000, 16'hBEEF, 0, 0, -1);
    run_frame(32'h6AB80000, 16'h0000, 1, 0, -1);
    for (int i = 0; i < 12; i++)
      run_frame($urandom, 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
